phys_free_list: RTL
===================

Name: phys_free_list

Overview:
Physical-register free list for the rename (map) stage. It supplies up to two free physical destination registers per cycle to the RAT and takes back up to two stale physical registers per cycle from commit. It keeps a speculative and a committed head pointer so a pipeline flush restores the list to the architectural state in one cycle. It sits beside the RAT and drives the map stage's free_list_empty stall.

Parameters:
PHY_REGS, 64, total physical registers; preg width PW = $clog2(PHY_REGS)
ARCH_REGS, 32, architectural registers; pregs 0..ARCH_REGS-1 are mapped at reset
DEPTH, PHY_REGS-ARCH_REGS, FIFO entries (power of two); pointer width = $clog2(DEPTH)+1 (extra wrap bit)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  pipeline flush; restore speculative state to committed state
alloc_req1  in  1  map inst1 valid && rf_we
alloc_req2  in  1  map inst2 valid && rf_we
alloc_fire  in  1  map stage handshake done (map_done); consume the granted pregs
alloc_preg1  out  PW  preg for inst1 (combinational)
alloc_preg2  out  PW  preg for inst2 (combinational)
free_list_empty  out  1  insufficient free pregs for this cycle's requests
free_count  out  $clog2(DEPTH)+1  speculative free entries, 0..DEPTH
retire_rf_we1  in  1  commit slot1 retires a register writer
retire_rf_we2  in  1  commit slot2 retires a register writer
retire_old_dest1  in  PW  stale preg released by slot1
retire_old_dest2  in  PW  stale preg released by slot2

Behaviour:
- State: fifo[DEPTH] of PW bits; spec_head, commit_head, tail pointers with wrap bit.
- Reset (async, reset==0): fifo[i]=ARCH_REGS+i; spec_head=commit_head=0; tail=DEPTH (full, wrap bit set). Outputs after reset: free_count=DEPTH, free_list_empty=0 with no requests, alloc_preg1=ARCH_REGS, alloc_preg2=ARCH_REGS+1 (both requested).
- free_count = tail - spec_head (modular, width includes wrap bit).
- Steering (combinational):
  - req1&req2: preg1=fifo[spec_head], preg2=fifo[spec_head+1].
  - req1 only: preg1=fifo[spec_head].
  - req2 only: preg2=fifo[spec_head].
  - Unrequested outputs are don't-care; drive fifo[spec_head].
- free_list_empty = free_count < (req1+req2). Purely combinational. Same-cycle releases are not bypassed; they become visible the next cycle.
- Allocate: on a clock edge with alloc_fire && !free_list_empty && !flush, spec_head += req1+req2. Otherwise spec_head holds, except on flush.
- Release: on every edge with reset high, including flush cycles:
  - fifo[tail] gets old_dest of the first asserted retire slot (slot1 before slot2); with both asserted, fifo[tail+1] gets old_dest2.
  - tail += we1+we2.
  - commit_head += we1+we2, since each retiring writer consumed one allocated entry.
- Flush: spec_head <= commit_head_next, i.e. commit_head including this cycle's increment. Allocation in a flush cycle is discarded.
- Wrap-around: all indices use the low $clog2(DEPTH) bits. Full is distinguished from empty by the wrap bit; free_count==DEPTH is legal.
- Invariants, each covered by an assertion in sim only:
  - commit_head never passes spec_head.
  - free_count never exceeds DEPTH.
  - A release with free_count+released>DEPTH is an upstream error; the assertion fires and no extra handling is done.
- Latency: grant visible in the same cycle as the request; pointer updates take effect at the next edge.
- Reset mid-operation: async return to the reset state regardless of flush, alloc_fire or retire inputs.

Test Plan:
- Reset then req1=req2=1, alloc_fire=1 for 16 cycles -> pregs 32,33,...,63 issued in order. free_count reaches 0; free_list_empty=1 with any request.
- free_count=1, req1=req2=1 -> free_list_empty=1 and spec_head unchanged. With req2 only -> empty=0, preg2=fifo[spec_head].
- Empty list, retire_rf_we1=1 old_dest=5 -> in that cycle empty stays 1. Next cycle free_count=1, preg1=5; the entry is written at index 0 after wrap.
- Allocate 6 pregs, retire 2, then flush -> spec_head=commit_head=2; free_count=DEPTH-2+2=DEPTH (tail advanced by 2).
- Flush coinciding with a 2-wide retire and alloc_fire -> the allocation is dropped. Both old_dests are appended, and spec_head equals the incremented commit_head.
- Run 200 cycles of random alloc/retire with a reference scoreboard model -> no preg is ever held twice, and the free set plus mapped set always totals PHY_REGS. Assert reset mid-burst -> free_count=DEPTH immediately.

Source files
------------

// File: rtl/phys_free_list.sv
// Free list of physical registers: two grants per cycle to rename, two releases per cycle from commit.
// Latency: grants are combinational from spec_head; pointer and entry updates land on the next edge.
// Backpressure: free_list_empty stalls the map stage when fewer free pregs remain than were requested.
module phys_free_list #(
    parameter int PHY_REGS  = 64,
    parameter int ARCH_REGS = 32,
    parameter int DEPTH     = PHY_REGS - ARCH_REGS,
    localparam int PW = $clog2(PHY_REGS),
    localparam int IW = $clog2(DEPTH),
    localparam int CW = IW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          alloc_req1,
    input  logic          alloc_req2,
    input  logic          alloc_fire,
    output logic [PW-1:0] alloc_preg1,
    output logic [PW-1:0] alloc_preg2,
    output logic          free_list_empty,
    output logic [CW-1:0] free_count,
    input  logic          retire_rf_we1,
    input  logic          retire_rf_we2,
    input  logic [PW-1:0] retire_old_dest1,
    input  logic [PW-1:0] retire_old_dest2
);

    logic [PW-1:0] fifo [DEPTH];
    logic [CW-1:0] spec_head;
    logic [CW-1:0] commit_head;
    logic [CW-1:0] tail;

    logic [CW-1:0] spec_head_next;
    logic [CW-1:0] commit_head_next;
    logic [CW-1:0] req_cnt;
    logic [CW-1:0] ret_cnt;
    logic [IW-1:0] head_idx;
    logic [IW-1:0] tail_idx;
    logic          alloc_take;

    assign req_cnt  = CW'(alloc_req1) + CW'(alloc_req2);
    assign ret_cnt  = CW'(retire_rf_we1) + CW'(retire_rf_we2);
    assign head_idx = spec_head[IW-1:0];
    assign tail_idx = tail[IW-1:0];

    assign free_count      = tail - spec_head;
    assign free_list_empty = free_count < req_cnt;

    // A lone inst2 request takes the head entry, not head+1.
    assign alloc_preg1 = fifo[head_idx];
    assign alloc_preg2 = (alloc_req1 && alloc_req2) ? fifo[head_idx + IW'(1)] : fifo[head_idx];

    assign alloc_take       = alloc_fire && !free_list_empty && !flush;
    assign commit_head_next = commit_head + ret_cnt;

    always_comb begin
        spec_head_next = spec_head;
        if (flush) begin
            spec_head_next = commit_head_next;
        end else if (alloc_take) begin
            spec_head_next = spec_head + req_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spec_head   <= '0;
            commit_head <= '0;
            tail        <= CW'(DEPTH);
        end else begin
            spec_head   <= spec_head_next;
            commit_head <= commit_head_next;
            tail        <= tail + ret_cnt;
        end
    end

    // Releases are packed: a lone slot2 release lands at tail, not tail+1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo[i] <= PW'(ARCH_REGS + i);
            end
        end else begin
            if (retire_rf_we1) begin
                fifo[tail_idx] <= retire_old_dest1;
            end
            if (retire_rf_we2) begin
                fifo[retire_rf_we1 ? tail_idx + IW'(1) : tail_idx] <= retire_old_dest2;
            end
        end
    end

    a_commit_behind_spec: assert property (@(posedge clk) disable iff (!reset)
        CW'(spec_head - commit_head) <= CW'(DEPTH));
    a_count_bound: assert property (@(posedge clk) disable iff (!reset)
        free_count <= CW'(DEPTH));
    a_release_overflow: assert property (@(posedge clk) disable iff (!reset)
        (int'(free_count) + int'(ret_cnt)) <= DEPTH);

endmodule
